// File: rtl/unidad_ejecucion_alu.sv
// Two-stage ALU execution unit (ADD/SUB/AND/OR/XOR/NOP) with valid/ready on both sides.
// Define ALU_BANDERAS_EN to build the zero/carry/overflow flag logic; otherwise flags read 0.
module unidad_ejecucion_alu #(
  parameter int ANCHO      = 32,
  parameter int ANCHO_CONT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            senial_ALU,
  input  logic [ANCHO-1:0]      operando_a,
  input  logic [ANCHO-1:0]      operando_b,
  input  logic                  entrada_valida,
  output logic                  entrada_lista,
  output logic [ANCHO-1:0]      resultado,
  output logic                  bandera_cero,
  output logic                  bandera_acarreo,
  output logic                  bandera_desborde,
  output logic                  salida_valida,
  input  logic                  salida_lista,
  output logic                  codigo_invalido,
  output logic [ANCHO_CONT-1:0] cuenta_ops
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  logic [2:0]            op_q;
  logic [ANCHO-1:0]      a_q, b_q;
  logic                  v1_q, v2_q;
  logic [ANCHO-1:0]      res_q, res_d;
  logic                  inv_q;
  logic [ANCHO_CONT-1:0] cnt_q;
  logic                  avanza2, es_calc, es_inv;

  assign avanza2       = !v2_q || salida_lista;
  assign entrada_lista = !v1_q || avanza2;
  assign es_calc       = (op_q <= OP_XOR);
  assign es_inv        = (op_q == 3'b101) || (op_q == 3'b110);

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (entrada_lista) begin
      v1_q <= entrada_valida;
      if (entrada_valida) begin
        op_q <= senial_ALU;
        a_q  <= operando_a;
        b_q  <= operando_b;
      end
    end
  end

  always_comb begin
    res_d = '0;
    case (op_q)
      OP_ADD:  res_d = a_q + b_q;
      OP_SUB:  res_d = a_q - b_q;
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      default: res_d = '0;
    endcase
  end

  // Stage 2: result register; NOP/invalid beats vanish here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      res_q <= '0;
      inv_q <= 1'b0;
    end else begin
      inv_q <= avanza2 && v1_q && es_inv;
      if (avanza2) begin
        v2_q <= v1_q && es_calc;
        if (v1_q && es_calc) res_q <= res_d;
      end
    end
  end

`ifdef ALU_BANDERAS_EN
  logic cero_d, acarreo_d, desborde_d;
  logic cero_q, acarreo_q, desborde_q;

  // Unsigned wrap on ADD shows up as a result smaller than either operand.
  always_comb begin
    cero_d     = (res_d == '0);
    acarreo_d  = 1'b0;
    desborde_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        acarreo_d  = (res_d < a_q);
        desborde_d = (a_q[ANCHO-1] == b_q[ANCHO-1]) && (res_d[ANCHO-1] != a_q[ANCHO-1]);
      end
      OP_SUB: begin
        acarreo_d  = (a_q < b_q);
        desborde_d = (a_q[ANCHO-1] != b_q[ANCHO-1]) && (res_d[ANCHO-1] != a_q[ANCHO-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cero_q     <= 1'b0;
      acarreo_q  <= 1'b0;
      desborde_q <= 1'b0;
    end else if (avanza2 && v1_q && es_calc) begin
      cero_q     <= cero_d;
      acarreo_q  <= acarreo_d;
      desborde_q <= desborde_d;
    end
  end

  assign bandera_cero     = cero_q;
  assign bandera_acarreo  = acarreo_q;
  assign bandera_desborde = desborde_q;
`else
  assign bandera_cero     = 1'b0;
  assign bandera_acarreo  = 1'b0;
  assign bandera_desborde = 1'b0;
`endif

  // Delivered-beat counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (v2_q && salida_lista && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign resultado       = res_q;
  assign salida_valida   = v2_q;
  assign codigo_invalido = inv_q;
  assign cuenta_ops      = cnt_q;

endmodule

// File: tb/tb_unidad_ejecucion_alu.sv
// Bench for unidad_ejecucion_alu: queue-based reference model plus directed vectors.
module tb_unidad_ejecucion_alu;
  localparam int W  = 32;
  localparam int CW = 4;
`ifdef ALU_BANDERAS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    senial_ALU = '0;
  logic [W-1:0]  operando_a = '0, operando_b = '0;
  logic          entrada_valida = 1'b0;
  logic          entrada_lista;
  logic [W-1:0]  resultado;
  logic          bandera_cero, bandera_acarreo, bandera_desborde;
  logic          salida_valida;
  logic          salida_lista = 1'b1;
  logic          codigo_invalido;
  logic [CW-1:0] cuenta_ops;

  unidad_ejecucion_alu #(.ANCHO(W), .ANCHO_CONT(CW)) dut (
    .clk(clk), .rst_n(rst_n), .senial_ALU(senial_ALU),
    .operando_a(operando_a), .operando_b(operando_b),
    .entrada_valida(entrada_valida), .entrada_lista(entrada_lista),
    .resultado(resultado), .bandera_cero(bandera_cero),
    .bandera_acarreo(bandera_acarreo), .bandera_desborde(bandera_desborde),
    .salida_valida(salida_valida), .salida_lista(salida_lista),
    .codigo_invalido(codigo_invalido), .cuenta_ops(cuenta_ops)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] r;
    logic z, c, v;
  } exp_t;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -MAXS - 64'sd1;

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint ua, ub, sa, sb, t, st;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    case (op)
      3'd0: begin
        t = ua + ub; st = sa + sb;
        e.r = t[31:0]; e.c = (t > 64'sd4294967295); e.v = (st > MAXS) || (st < MINS);
      end
      3'd1: begin
        t = ua - ub; st = sa - sb;
        e.r = t[31:0]; e.c = (ua < ub); e.v = (st > MAXS) || (st < MINS);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    if (!FL) begin e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; end
    return e;
  endfunction

  exp_t          expq[$];
  logic [CW-1:0] cnt_m = '0;
  int            n_acc = 0, n_out = 0, n_inv = 0, n_pulsos = 0;
  bit            hold = 1'b0;
  logic [W-1:0]  hold_r;
  logic [2:0]    hold_f;

  // Reference model and per-cycle comparison, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      expq.delete();
      cnt_m = '0;
      hold  = 1'b0;
    end else begin
      if (hold) begin
        chk("estable_valida", 64'(salida_valida), 64'(1));
        chk("estable_resultado", 64'(resultado), 64'(hold_r));
        chk("estable_banderas", 64'({bandera_cero, bandera_acarreo, bandera_desborde}), 64'(hold_f));
      end
      if (salida_valida) begin
        if (expq.size() == 0) begin
          chk("salida_inesperada", 64'(1), 64'(0));
        end else begin
          e = expq[0];
          chk("resultado", 64'(resultado), 64'(e.r));
          chk("bandera_cero", 64'(bandera_cero), 64'(e.z));
          chk("bandera_acarreo", 64'(bandera_acarreo), 64'(e.c));
          chk("bandera_desborde", 64'(bandera_desborde), 64'(e.v));
        end
      end
      chk("cuenta_ops", 64'(cuenta_ops), 64'(cnt_m));
      if (codigo_invalido) n_pulsos++;
      hold   = salida_valida && !salida_lista;
      hold_r = resultado;
      hold_f = {bandera_cero, bandera_acarreo, bandera_desborde};
      if (salida_valida && salida_lista) begin
        if (expq.size() != 0) void'(expq.pop_front());
        n_out++;
        if (cnt_m != '1) cnt_m = cnt_m + 1'b1;
      end
      if (entrada_valida && entrada_lista) begin
        n_acc++;
        if (senial_ALU <= 3'd4) expq.push_back(model(senial_ALU, operando_a, operando_b));
        else if (senial_ALU == 3'd5 || senial_ALU == 3'd6) n_inv++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    senial_ALU = op; operando_a = a; operando_b = b; entrada_valida = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (entrada_lista) begin ok = 1'b1; break; end
    end
    if (!ok) chk("timeout_entrada", 64'(0), 64'(1));
    @(posedge clk); #1;
    entrada_valida = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, o0, p0;
    // Reset with a beat offered
    entrada_valida = 1'b1; senial_ALU = 3'd0; operando_a = 32'd9; operando_b = 32'd9;
    #23;
    chk("rst_resultado", 64'(resultado), 64'(0));
    chk("rst_salida_valida", 64'(salida_valida), 64'(0));
    chk("rst_cero", 64'(bandera_cero), 64'(0));
    chk("rst_acarreo", 64'(bandera_acarreo), 64'(0));
    chk("rst_desborde", 64'(bandera_desborde), 64'(0));
    chk("rst_invalido", 64'(codigo_invalido), 64'(0));
    chk("rst_cuenta", 64'(cuenta_ops), 64'(0));
    chk("rst_entrada_lista", 64'(entrada_lista), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1; entrada_valida = 1'b0;
    tick(1);

    // ADD 5+7: visible one edge after acceptance
    send(3'd0, 32'd5, 32'd7);
    tick(1);
    chk("lat_valida", 64'(salida_valida), 64'(1));
    chk("add_5_7", 64'(resultado), 64'(12));
    tick(1);
    chk("cuenta_tras_add", 64'(cuenta_ops), 64'(1));

    send(3'd0, 32'hFFFF_FFFF, 32'd1);
    tick(1);
    chk("add_wrap_res", 64'(resultado), 64'(0));
    chk("add_wrap_cero", 64'(bandera_cero), 64'(FL));
    chk("add_wrap_acarreo", 64'(bandera_acarreo), 64'(FL));
    chk("add_wrap_desborde", 64'(bandera_desborde), 64'(0));
    send(3'd0, 32'h7FFF_FFFF, 32'd1);
    tick(1);
    chk("add_ovf_res", 64'(resultado), 64'h8000_0000);
    chk("add_ovf_desborde", 64'(bandera_desborde), 64'(FL));
    send(3'd1, 32'd3, 32'd5);
    tick(1);
    chk("sub_3_5_res", 64'(resultado), 64'hFFFF_FFFE);
    chk("sub_3_5_acarreo", 64'(bandera_acarreo), 64'(FL));
    tick(2);

    // Backpressure: only two beats fit while the output is blocked
    salida_lista = 1'b0;
    n0 = n_acc;
    senial_ALU = 3'd0; operando_a = 32'd10; operando_b = 32'd20; entrada_valida = 1'b1;
    tick(1);
    senial_ALU = 3'd1; operando_a = 32'd100; operando_b = 32'd1;
    tick(1);
    senial_ALU = 3'd3; operando_a = 32'hF0; operando_b = 32'h0F;
    tick(3);
    chk("bp_entrada_lista", 64'(entrada_lista), 64'(0));
    chk("bp_aceptados", 64'(n_acc - n0), 64'(2));
    chk("bp_valida", 64'(salida_valida), 64'(1));
    chk("bp_resultado", 64'(resultado), 64'(30));
    salida_lista = 1'b1;
    #1;
    chk("bp_lista_combinacional", 64'(entrada_lista), 64'(1));
    tick(1);
    chk("drain_1", 64'(resultado), 64'(99));
    senial_ALU = 3'd4; operando_a = 32'hFF; operando_b = 32'h0F;
    tick(1);
    chk("drain_2", 64'(resultado), 64'hFF);
    entrada_valida = 1'b0;
    tick(1);
    chk("drain_3", 64'(resultado), 64'hF0);
    tick(2);
    chk("bp_total", 64'(n_acc - n0), 64'(4));

    // AND, NOP, invalid 101, XOR
    o0 = n_out; p0 = n_pulsos;
    send(3'd2, 32'hC, 32'hA);
    send(3'd7, 32'h1, 32'h1);
    send(3'd5, 32'h2, 32'h2);
    send(3'd4, 32'h5, 32'h3);
    tick(1);
    chk("xor_5_3", 64'(resultado), 64'h6);
    tick(4);
    chk("nop_beats", 64'(n_out - o0), 64'(2));
    chk("nop_cuenta", 64'(cuenta_ops), 64'(10));
    chk("nop_pulsos", 64'(n_pulsos - p0), 64'(1));

    // Asynchronous reset with beats in flight
    salida_lista = 1'b0;
    send(3'd0, 32'd1, 32'd2);
    send(3'd0, 32'd3, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valida", 64'(salida_valida), 64'(0));
    chk("mid_rst_resultado", 64'(resultado), 64'(0));
    chk("mid_rst_cuenta", 64'(cuenta_ops), 64'(0));
    chk("mid_rst_lista", 64'(entrada_lista), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1; salida_lista = 1'b1;
    tick(1);

    // Assorted vectors, then saturate the 4-bit counter
    send(3'd1, 32'h8000_0000, 32'd1);
    send(3'd0, 32'h8000_0000, 32'h8000_0000);
    send(3'd2, 32'hFFFF_0000, 32'h0F0F_0F0F);
    send(3'd6, 32'd0, 32'd0);
    send(3'd3, 32'h1234_0000, 32'h0000_5678);
    send(3'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    send(3'd1, 32'd5, 32'd5);
    tick(1);
    chk("sub_5_5_cero", 64'(bandera_cero), 64'(FL));
    for (int i = 0; i < 20; i++) send(3'd0, 32'(i), 32'(3 * i));
    tick(4);
    chk("cuenta_saturada", 64'(cuenta_ops), 64'(15));
    chk("cola_vacia", 64'(expq.size()), 64'(0));
    chk("pulsos_invalidos", 64'(n_pulsos), 64'(n_inv));
    chk("pulsos_total", 64'(n_pulsos), 64'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
